matrix_decoder: RTL and testbench

//  Receive-side counterpart of the matrix encoder. Reads a frame of DEPTH encoded words from the

---
 rtl/matrix_codec_pkg.sv | 17 +
 rtl/matrix_decoder_if.sv | 30 +++
 rtl/address_counter.sv | 37 +++
 rtl/matrix_decoder.sv | 106 ++++++++++
 tb/tb_matrix_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_codec_pkg.sv
// Shared definitions for the matrix encoder/decoder pair: FSM state encoding and
// default frame geometry.
package matrix_codec_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StLatch = 3'd2,
    StWrite = 3'd3,
    StCount = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 16;

endpackage

// File: rtl/matrix_decoder_if.sv
// Sequencer handshake plus encoded-frame read port and decoded-frame write port.
interface matrix_decoder_if
  import matrix_codec_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/address_counter.sv
// Frame word counter: synchronous clear, increments on en, saturates at DEPTH-1.
module address_counter #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          co
);

  logic [AW-1:0] cnt_q, cnt_d;

  assign co  = (cnt_q == AW'(DEPTH - 1));
  assign cnt = cnt_q;

  // Holding at the terminal value keeps non-power-of-2 frames from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !co) begin
      cnt_d = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_decoder.sv
// Undoes differential frame encoding: raw[i] = enc[i] ^ raw[i-1], one word per
// four-cycle read/latch/write/count pass.
module matrix_decoder
  import matrix_codec_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic              clk,
  input logic              rst,
  matrix_decoder_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] in_q, prev_q, decoded;
  logic [AW-1:0]    cnt;
  logic             co, cnt_clr, cnt_en;

  logic             rd_en, wr_en, busy, done;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [WIDTH-1:0] wr_data;

  address_counter #(
    .DEPTH(DEPTH)
  ) u_address_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .co  (co)
  );

  assign decoded = in_q ^ prev_q;

  always_comb begin
    state_d = StIdle;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b1;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      StIdle: begin
        busy    = 1'b0;
        cnt_clr = 1'b1;
        state_d = bus.start ? StRead : StIdle;
      end
      StRead: begin
        rd_en   = 1'b1;
        rd_addr = cnt;
        state_d = StLatch;
      end
      StLatch: state_d = StWrite;
      StWrite: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = decoded;
        state_d = StCount;
      end
      StCount: begin
        cnt_en  = 1'b1;
        state_d = co ? StDone : StRead;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      in_q    <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StLatch) begin
        in_q <= bus.rd_data;
      end
      // prev carries the last decoded word; cleared so every frame starts from raw[-1] = 0.
      if (state_q == StIdle) begin
        prev_q <= '0;
      end else if (state_q == StWrite) begin
        prev_q <= decoded;
      end
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule

// File: tb/tb_matrix_decoder.sv
// Directed bench for matrix_decoder: DEPTH=4 and DEPTH=5 instances with registered-read
// memory models and write/done loggers.
module tb_matrix_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_decoder_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  matrix_decoder_if #(.WIDTH(8), .DEPTH(5)) if5 ();

  matrix_decoder #(.WIDTH(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  matrix_decoder #(.WIDTH(8), .DEPTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));

  logic [7:0] enc4 [4];
  logic [7:0] enc5 [8];

  always @(posedge clk) if (if4.rd_en) if4.rd_data <= enc4[if4.rd_addr];
  always @(posedge clk) if (if5.rd_en) if5.rd_data <= enc5[if5.rd_addr];

  int         wa4[$];
  logic [7:0] wd4[$];
  int         wa5[$];
  logic [7:0] wd5[$];
  int         done4_cnt = 0;
  int         done5_cnt = 0;
  int         oob5 = 0;

  always @(negedge clk) begin
    if (if4.wr_en) begin
      wa4.push_back(int'(if4.wr_addr));
      wd4.push_back(if4.wr_data);
    end
    if (if5.wr_en) begin
      wa5.push_back(int'(if5.wr_addr));
      wd5.push_back(if5.wr_data);
    end
    if (if4.done) done4_cnt++;
    if (if5.done) done5_cnt++;
    if ((if5.rd_en && if5.rd_addr > 3'd4) || (if5.wr_en && if5.wr_addr > 3'd4)) oob5++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wa4.delete(); wd4.delete(); wa5.delete(); wd5.delete();
    done4_cnt = 0; done5_cnt = 0; oob5 = 0;
  endtask

  // Counts negedges until done4 is seen, bounded by limit.
  task automatic wait_done4(input int limit, output int n);
    n = 0;
    while (!if4.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("done4_timeout", 32'(n < limit), 32'd1);
  endtask

  task automatic check_frame4(input string tag, input int base, input logic [7:0] exp [4]);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 32'(wa4[base+i]), 32'(i));
      check_eq($sformatf("%s_data%0d", tag, i), 32'(wd4[base+i]), 32'(exp[i]));
    end
  endtask

  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];
  int n, k, idle_hits;

  initial begin
    if4.start = 1'b0;
    if5.start = 1'b0;
    enc4 = '{8'h01, 8'h03, 8'h06, 8'h0C};
    exp_a = '{8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 0; i < 8; i++) enc5[i] = (i < 5) ? 8'hFF : 8'h55;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(if4.busy), 0);
    check_eq("rst_done", 32'(if4.done), 0);
    check_eq("rst_rd_en", 32'(if4.rd_en), 0);
    check_eq("rst_wr_en", 32'(if4.wr_en), 0);
    check_eq("rst_rd_addr", 32'(if4.rd_addr), 0);
    check_eq("rst_wr_addr", 32'(if4.wr_addr), 0);
    check_eq("rst_wr_data", 32'(if4.wr_data), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();

    // 1: single frame, latency 17
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    check_eq("t1_busy_first", 32'(if4.busy), 1);
    check_eq("t1_rd_en_first", 32'(if4.rd_en), 1);
    wait_done4(60, n);
    check_eq("t1_latency", 32'(n + 1), 32'd17);
    check_eq("t1_nwrites", 32'(wd4.size()), 32'd4);
    if (wd4.size() == 4) check_frame4("t1", 0, exp_a);
    @(negedge clk);
    check_eq("t1_done_after", 32'(if4.done), 0);
    check_eq("t1_busy_after", 32'(if4.busy), 0);
    check_eq("t1_done_pulses", 32'(done4_cnt), 32'd1);

    // 2: back-to-back frames with start held high
    repeat (2) @(negedge clk);
    clear_logs();
    if4.start = 1'b1;
    @(negedge clk);
    wait_done4(60, n);
    @(negedge clk);
    check_eq("t2_idle_gap_busy", 32'(if4.busy), 0);
    wait_done4(60, n);
    if4.start = 1'b0;
    check_eq("t2_second_latency", 32'(n + 1), 32'd18);
    check_eq("t2_nwrites", 32'(wd4.size()), 32'd8);
    if (wd4.size() == 8) begin
      check_frame4("t2a", 0, exp_a);
      check_frame4("t2b", 4, exp_a);
    end
    repeat (3) @(negedge clk);
    check_eq("t2_done_pulses", 32'(done4_cnt), 32'd2);
    check_eq("t2_busy_end", 32'(if4.busy), 0);

    // 3: start pulse during WRITE of word 1 is ignored
    clear_logs();
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    k = 0;
    while (!(if4.wr_en && if4.wr_addr == 2'd1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("t3_reach_write1", 32'(k < 40), 32'd1);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_done4(60, n);
    repeat (25) @(negedge clk);
    check_eq("t3_nwrites", 32'(wd4.size()), 32'd4);
    check_eq("t3_done_pulses", 32'(done4_cnt), 32'd1);
    check_eq("t3_busy_end", 32'(if4.busy), 0);

    // 4: reset in LATCH of word 2, then a clean frame
    clear_logs();
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    k = 0;
    while (!(if4.rd_en && if4.rd_addr == 2'd2) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_reach_read2", 32'(k < 40), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t4_rst_wr_en", 32'(if4.wr_en), 0);
    check_eq("t4_rst_done", 32'(if4.done), 0);
    check_eq("t4_rst_busy", 32'(if4.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("t4_writes_before_rst", 32'(wd4.size()), 32'd2);
    check_eq("t4_no_done", 32'(done4_cnt), 0);
    clear_logs();
    enc4 = '{8'hA5, 8'h0F, 8'hF0, 8'h00};
    exp_b = '{8'hA5, 8'hAA, 8'h5A, 8'h5A};
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_done4(60, n);
    check_eq("t4_latency", 32'(n + 1), 32'd17);
    check_eq("t4_nwrites", 32'(wd4.size()), 32'd4);
    if (wd4.size() == 4) check_frame4("t4", 0, exp_b);

    // 5: DEPTH=5, all-FF frame
    repeat (2) @(negedge clk);
    clear_logs();
    if5.start = 1'b1;
    @(negedge clk);
    if5.start = 1'b0;
    n = 1;
    while (!if5.done && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_latency", 32'(n), 32'd21);
    check_eq("t5_nwrites", 32'(wd5.size()), 32'd5);
    if (wd5.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check_eq($sformatf("t5_addr%0d", i), 32'(wa5[i]), 32'(i));
        check_eq($sformatf("t5_data%0d", i), 32'(wd5[i]), (i % 2 == 0) ? 32'hFF : 32'h00);
      end
    end
    repeat (3) @(negedge clk);
    check_eq("t5_oob", 32'(oob5), 0);
    check_eq("t5_done_pulses", 32'(done5_cnt), 32'd1);

    // 6: long idle with start low
    clear_logs();
    idle_hits = 0;
    repeat (50) begin
      @(negedge clk);
      if (if4.rd_en || if4.wr_en || if4.busy || if5.rd_en || if5.wr_en || if5.busy) idle_hits++;
    end
    check_eq("t6_idle_activity", 32'(idle_hits), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
